fft_3_reorder: RTL

//  Output stage directly downstream of the 8-point streaming FFT (fft_3).
//  fft_3 emits one complex bin per clk, continuously, in bit-reversed order.

---
 rtl/fft_pkg.sv | 31 +++
 rtl/fft_3_reorder_ram.sv | 38 +++
 rtl/fft_3_reorder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg
//   Shared definitions for the 8-point streaming FFT (fft_3) and its output
//   reorder stage (fft_3_reorder). Both blocks take the bin-order definition
//   from here, so the FFT's output order and the reorder's address mapping
//   cannot drift apart.
//
//   FFT_CBW  log2 of the default frame length
//   FFT_N    default frame length
//   bitrev   reverses the low 'bits' bits of an index, upper result bits are 0
package fft_pkg;

  localparam int FFT_CBW = 3;
  localparam int FFT_N   = 1 << FFT_CBW;

  // Shift-based reversal avoids variable bit-select widths: each step moves
  // the current LSB of the source into the bottom of the result.
  function automatic logic [15:0] bitrev(input logic [15:0] idx, input int bits);
    logic [15:0] r;
    logic [15:0] v;
    r = '0;
    v = idx;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) begin
        r = {r[14:0], v[0]};
        v = v >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_3_reorder_ram.sv
// fft_3_reorder_ram
//   Ping-pong frame buffer for the reorder stage: 2*N words of 2*DBW bits.
//   One write port and one read port whose data is registered (1 clk latency).
//   The upper address bit selects the bank; the owner guarantees that reads
//   and writes never target the same bank in the same clk.
//
//   clk    clock
//   we     write enable
//   waddr  write address {bank, index}
//   wdata  write data
//   re     read enable; rdata updates only when set
//   raddr  read address {bank, index}
//   rdata  registered read data
module fft_3_reorder_ram #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // No reset: contents are always written before they are read back.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_3_reorder.sv
// fft_3_reorder
//   Sits directly after the streaming FFT. The FFT emits one complex bin per
//   clk in bit-reversed order; each frame is written into one bank of a
//   ping-pong RAM at its natural-order position and, once complete, replayed
//   from that bank in natural order while the next frame fills the other bank.
//
//   clk         clock, posedge
//   rstx        async active-low reset
//   clear       sync clear back to the reset state (wins over start)
//   start       din is the first FFT output of a frame
//   din         {imag, real} FFT output, one per clk
//   dout        reordered bin, same packing, 0 when not valid
//   dout_valid  dout holds a bin
//   dout_first  dout holds bin 0 of a frame
//
//   Timing: start sampled at edge T -> bin 0 on dout after edge T+N+1.
//   Pipeline: read issue (ractive) -> RAM data reg -> dout reg.
module fft_3_reorder
  import fft_pkg::*;
#(
  parameter int DBW = 8,
  parameter int CBW = 3
) (
  input  logic           clk,
  input  logic           rstx,
  input  logic           clear,
  input  logic           start,
  input  logic [2*DBW-1:0] din,
  output logic [2*DBW-1:0] dout,
  output logic           dout_valid,
  output logic           dout_first
);

  localparam int N      = 1 << CBW;
  localparam int DW     = 2 * DBW;
  localparam int STAGES = 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // write side
  logic [0:0]     state;
  logic [CBW-1:0] wcnt;
  logic [CBW-1:0] wsel;
  logic [CBW-1:0] widx;
  logic           wbank;
  logic           we;
  logic           frame_done;

  // read side
  logic [CBW-1:0] rcnt;
  logic           rbank;
  logic           ractive;

  // vld_pipe[0]/fst_pipe[0] align with RAM rdata, [STAGES] with dout
  logic [STAGES:0] vld_pipe;
  logic [STAGES:0] fst_pipe;
  logic [DW-1:0]   rdata;

  // A start in RUN restarts the frame at bin-order index 0, which also covers
  // the aligned case (wcnt==0) with no special handling.
  always_comb begin
    we         = 1'b0;
    frame_done = 1'b0;
    wsel       = start ? '0 : wcnt;
    widx       = CBW'(bitrev(16'(wsel), CBW));
    if (!clear) begin
      if (state == RUN) begin
        we         = 1'b1;
        frame_done = !start && (wcnt == CBW'(N - 1));
      end else if (start) begin
        we = 1'b1;
      end
    end
  end

  // Write side FSM: the bank flips with the last write of a frame so the
  // next frame's first sample (next clk) already lands in the other bank.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      state <= IDLE;
      wcnt  <= '0;
      wbank <= 1'b0;
    end else if (clear) begin
      state <= IDLE;
      wcnt  <= '0;
      wbank <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            wcnt  <= CBW'(1);
          end
        end
        RUN: begin
          wcnt <= start ? CBW'(1) : wcnt + CBW'(1);
          if (frame_done) wbank <= ~wbank;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read side: a completed frame (re)starts the readout even mid-readout,
  // which with back-to-back frames lands exactly after rcnt==N-1.
  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      rcnt    <= '0;
      rbank   <= 1'b0;
      ractive <= 1'b0;
    end else if (clear) begin
      rcnt    <= '0;
      rbank   <= 1'b0;
      ractive <= 1'b0;
    end else if (frame_done) begin
      rcnt    <= '0;
      rbank   <= wbank;
      ractive <= 1'b1;
    end else if (ractive) begin
      rcnt <= rcnt + CBW'(1);
      if (rcnt == CBW'(N - 1)) ractive <= 1'b0;
    end
  end

  fft_3_reorder_ram #(
    .DW (DW),
    .AW (CBW + 1)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({wbank, widx}),
    .wdata (din),
    .re    (ractive),
    .raddr ({rbank, rcnt}),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rstx) begin
    if (!rstx) begin
      vld_pipe <= '0;
      fst_pipe <= '0;
      dout     <= '0;
    end else if (clear) begin
      vld_pipe <= '0;
      fst_pipe <= '0;
      dout     <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], ractive};
      fst_pipe <= {fst_pipe[STAGES-1:0], ractive && (rcnt == '0)};
      // RAM data is unreset and stale between frames; keep dout clean.
      dout     <= vld_pipe[0] ? rdata : '0;
    end
  end

  assign dout_valid = vld_pipe[STAGES];
  assign dout_first = fst_pipe[STAGES];

endmodule
